// File: rtl/delay_stepper_pkg.sv
// Constants shared by the stepper and the delay control register that feeds it.
package delay_stepper_pkg;
  localparam int                 DELAY_W     = 4;
  localparam logic [DELAY_W-1:0] DELAY_PAUSE = 4'd0;
endpackage

// File: rtl/tick_prescaler.sv
// Base tick generator: free-running 0..TICK_CYCLES-1 counter, tick is combinational.
// No backpressure; en=0 freezes the count, clr zeroes it on the next edge.
module tick_prescaler
  import delay_stepper_pkg::*;
#(
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/delay_stepper.sv
// Periodic one-cycle step strobe plus wrapping position, interval = delay * TICK_CYCLES clocks.
// Step and pos are registered (one edge after the qualifying tick); no backpressure, delay==0 pauses.
module delay_stepper
  import delay_stepper_pkg::*;
#(
  parameter int TICK_CYCLES = 5_000_000,
  parameter int POS_WIDTH   = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DELAY_W-1:0]   delay,
  input  logic                 run,
  input  logic                 dir,
  input  logic                 restart,
  output logic                 step,
  output logic [POS_WIDTH-1:0] pos
);
  logic                 tick;
  logic [DELAY_W-1:0]   ivl_q, ivl_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 step_q, step_d;

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (run),
    .clr    (restart),
    .tick   (tick)
  );

  always_comb begin
    ivl_d  = ivl_q;
    pos_d  = pos_q;
    step_d = 1'b0;
    if (restart) begin
      ivl_d = '0;
      pos_d = '0;
    end else if (run && tick) begin
      if (delay == DELAY_PAUSE) begin
        ivl_d = '0;
      // >= rather than == so lowering delay below ivl fires on the next tick
      end else if (ivl_q >= (delay - DELAY_W'(1))) begin
        ivl_d  = '0;
        step_d = 1'b1;
        pos_d  = dir ? (pos_q + POS_WIDTH'(1)) : (pos_q - POS_WIDTH'(1));
      end else begin
        ivl_d = ivl_q + DELAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ivl_q  <= '0;
      pos_q  <= '0;
      step_q <= 1'b0;
    end else begin
      ivl_q  <= ivl_d;
      pos_q  <= pos_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;
  assign pos  = pos_q;
endmodule
